swipt_frame_link: RTL and testbench

//  Parametrised half-duplex SWIPT link controller: the next generation of the Data block.
//  - Frames a payload, serialises it on dout at a slow bit rate, then opens a reply window

---
 rtl/swipt_frame_link.sv | 225 ++++++++++++++++++++++
 tb/tb_swipt_frame_link.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/swipt_frame_link.sv
// swipt_frame_link: half-duplex SWIPT link controller.
// Frames a payload, shifts it out MSB first at a slow bit rate, then opens a reply
// window (blind part followed by a listen part) and retries on timeout or bad checksum.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for start with enable high
// S_TX     | serialising the latched frame on o_dout
// S_BLIND  | reply window, receiver still disabled
// S_LISTEN | reply window, receiver enabled, waiting for rx_valid or timeout
// S_RETRY  | one quiet cycle before the frame is sent again
// S_DONE   | done pulse, status and reply final
module swipt_frame_link #(
  parameter int DATA_W      = 16,
  parameter int REPLY_W     = 8,
  parameter int BIT_PERIOD  = 200000,
  parameter int BLIND_CYC   = 1000000,
  parameter int TIMEOUT_CYC = 10000000,
  parameter int MAX_RETRY   = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic               i_start,
  input  logic [1:0]         i_mode,
  input  logic [1:0]         i_type,
  input  logic [DATA_W-1:0]  i_tx_data,
  input  logic               i_rx_valid,
  input  logic [REPLY_W-1:0] i_rx_data,
  input  logic               i_rx_chk_ok,
  output logic               o_busy,
  output logic               o_write,
  output logic               o_read,
  output logic               o_dout,
  output logic               o_rx_en,
  output logic               o_done,
  output logic [1:0]         o_status,
  output logic [REPLY_W-1:0] o_reply,
  output logic [3:0]         o_retry_cnt
);

  localparam int FRAME_W = DATA_W + 15;
  localparam int BIT_CW  = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int WIN_CW  = $clog2(TIMEOUT_CYC);
  localparam int IDX_CW  = $clog2(FRAME_W);

  localparam logic [BIT_CW-1:0] BIT_LAST     = BIT_CW'(BIT_PERIOD - 1);
  localparam logic [BIT_CW-1:0] BIT_ONE      = BIT_CW'(1);
  localparam logic [WIN_CW-1:0] BLIND_LAST   = WIN_CW'(BLIND_CYC - 1);
  localparam logic [WIN_CW-1:0] TIMEOUT_LAST = WIN_CW'(TIMEOUT_CYC - 1);
  localparam logic [WIN_CW-1:0] WIN_ONE      = WIN_CW'(1);
  localparam logic [IDX_CW-1:0] IDX_LAST     = IDX_CW'(FRAME_W - 1);
  localparam logic [IDX_CW-1:0] IDX_ONE      = IDX_CW'(1);
  localparam logic [3:0]        RETRY_MAX    = 4'(MAX_RETRY);

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_TIMEOUT  = 2'b01;
  localparam logic [1:0] ST_CHK_FAIL = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_BLIND,
    S_LISTEN,
    S_RETRY,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [FRAME_W-1:0]   r_frame;
  logic [FRAME_W-1:0]   r_shift;
  logic [BIT_CW-1:0]    r_bit_tmr;
  logic [IDX_CW-1:0]    r_bit_idx;
  logic [WIN_CW-1:0]    r_win_cnt;
  logic [3:0]           r_retry_cnt;
  logic [1:0]           r_status;
  logic [REPLY_W-1:0]   r_reply;
  logic                 r_busy;
  logic                 r_write;
  logic                 r_read;
  logic                 r_dout;
  logic                 r_rx_en;
  logic                 r_done;

  logic [FRAME_W-1:0]   w_frame;
  logic                 w_fail;
  logic [1:0]           w_fail_code;
  logic                 w_can_retry;

  // Frame layout: preamble, mode, type, payload, payload parity, trailer.
  assign w_frame = {6'b101010, i_mode, i_type, i_tx_data, ^i_tx_data, 4'b0101};

  // A listen-phase attempt fails on a bad-checksum reply or, with no reply, at the last window count.
  assign w_fail      = (r_state == S_LISTEN) &&
                       (i_rx_valid ? !i_rx_chk_ok : (r_win_cnt == TIMEOUT_LAST));
  assign w_fail_code = i_rx_valid ? ST_CHK_FAIL : ST_TIMEOUT;
  assign w_can_retry = (r_retry_cnt < RETRY_MAX);

  // Link sequencer with registered outputs; enable low aborts but keeps reply and status.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_frame     <= '0;
      r_shift     <= '0;
      r_bit_tmr   <= '0;
      r_bit_idx   <= '0;
      r_win_cnt   <= '0;
      r_retry_cnt <= '0;
      r_status    <= ST_OK;
      r_reply     <= '0;
      r_busy      <= 1'b0;
      r_write     <= 1'b0;
      r_read      <= 1'b0;
      r_dout      <= 1'b0;
      r_rx_en     <= 1'b0;
      r_done      <= 1'b0;
    end else if (!i_enable) begin
      r_state     <= S_IDLE;
      r_bit_tmr   <= '0;
      r_bit_idx   <= '0;
      r_win_cnt   <= '0;
      r_retry_cnt <= '0;
      r_busy      <= 1'b0;
      r_write     <= 1'b0;
      r_read      <= 1'b0;
      r_dout      <= 1'b0;
      r_rx_en     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_frame     <= w_frame;
            r_shift     <= w_frame;
            r_retry_cnt <= '0;
            r_bit_tmr   <= BIT_LAST;
            r_bit_idx   <= IDX_LAST;
            r_busy      <= 1'b1;
            r_write     <= 1'b1;
            r_dout      <= w_frame[FRAME_W-1];
            r_state     <= S_TX;
          end
        end
        S_TX: begin
          if (r_bit_tmr != '0) begin
            r_bit_tmr <= r_bit_tmr - BIT_ONE;
          end else if (r_bit_idx == '0) begin
            r_write   <= 1'b0;
            r_dout    <= 1'b0;
            r_read    <= 1'b1;
            r_win_cnt <= '0;
            r_state   <= S_BLIND;
          end else begin
            r_shift   <= {r_shift[FRAME_W-2:0], 1'b0};
            r_dout    <= r_shift[FRAME_W-2];
            r_bit_idx <= r_bit_idx - IDX_ONE;
            r_bit_tmr <= BIT_LAST;
          end
        end
        S_BLIND: begin
          r_win_cnt <= r_win_cnt + WIN_ONE;
          if (r_win_cnt == BLIND_LAST) begin
            r_rx_en <= 1'b1;
            r_state <= S_LISTEN;
          end
        end
        S_LISTEN: begin
          if (i_rx_valid && i_rx_chk_ok) begin
            r_reply  <= i_rx_data;
            r_status <= ST_OK;
            r_read   <= 1'b0;
            r_rx_en  <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else if (w_fail) begin
            r_read  <= 1'b0;
            r_rx_en <= 1'b0;
            if (w_can_retry) begin
              r_retry_cnt <= r_retry_cnt + 4'd1;
              r_state     <= S_RETRY;
            end else begin
              r_status <= w_fail_code;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end else begin
            r_win_cnt <= r_win_cnt + WIN_ONE;
          end
        end
        S_RETRY: begin
          r_shift   <= r_frame;
          r_bit_tmr <= BIT_LAST;
          r_bit_idx <= IDX_LAST;
          r_write   <= 1'b1;
          r_dout    <= r_frame[FRAME_W-1];
          r_state   <= S_TX;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_write <= 1'b0;
          r_read  <= 1'b0;
          r_dout  <= 1'b0;
          r_rx_en <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_write     = r_write;
  assign o_read      = r_read;
  assign o_dout      = r_dout;
  assign o_rx_en     = r_rx_en;
  assign o_done      = r_done;
  assign o_status    = r_status;
  assign o_reply     = r_reply;
  assign o_retry_cnt = r_retry_cnt;

endmodule

// File: tb/tb_swipt_frame_link.sv
// Bench for swipt_frame_link: a timeline model (cycles since the current attempt's first
// TX bit) predicts every output each cycle; directed scenarios add hand-computed literals.
module tb_swipt_frame_link;

  localparam int BP      = 4;
  localparam int BLIND   = 8;
  localparam int TMO     = 40;
  localparam int MAXR    = 1;
  localparam int FW      = 31;
  localparam int TX_LEN  = FW * BP;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [1:0] typ = 2'b00;
  logic [15:0] tx_data = 16'h0000;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_chk_ok = 1'b0;
  logic       busy, wr, rd, dout, rx_en, done;
  logic [1:0] status;
  logic [7:0] reply;
  logic [3:0] retry_cnt;

  int checks = 0;
  int passed = 0;
  int done_cnt = 0;

  swipt_frame_link #(
    .DATA_W(16), .REPLY_W(8), .BIT_PERIOD(BP), .BLIND_CYC(BLIND),
    .TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_start(start),
    .i_mode(mode), .i_type(typ), .i_tx_data(tx_data),
    .i_rx_valid(rx_valid), .i_rx_data(rx_data), .i_rx_chk_ok(rx_chk_ok),
    .o_busy(busy), .o_write(wr), .o_read(rd), .o_dout(dout), .o_rx_en(rx_en),
    .o_done(done), .o_status(status), .o_reply(reply), .o_retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [30:0] mk_frame(input logic [1:0] md, input logic [1:0] ty,
                                           input logic [15:0] d);
    return {6'b101010, md, ty, d, ^d, 4'b0101};
  endfunction

  // ---------------- timeline model ----------------
  logic        m_busy = 1'b0, m_done = 1'b0, m_gap = 1'b0;
  int          m_t = 0;
  int          m_retry = 0;
  logic [1:0]  m_status = 2'b00;
  logic [7:0]  m_reply = 8'h00;
  logic [30:0] m_frame = '0;

  task automatic attempt_failed(input logic [1:0] code);
    if (m_retry < MAXR) begin
      m_retry++;
      m_gap = 1'b1;
    end else begin
      m_status = code;
      m_done = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_gap = 0; m_t = 0; m_retry = 0;
      m_status = 2'b00; m_reply = 8'h00;
    end else if (!enable) begin
      m_busy = 0; m_done = 0; m_gap = 0; m_t = 0; m_retry = 0;
    end else if (m_done) begin
      m_done = 0; m_busy = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_retry = 0; m_t = 0; m_gap = 0;
        m_frame = mk_frame(mode, typ, tx_data);
      end
    end else if (m_gap) begin
      m_gap = 0; m_t = 0;
    end else begin
      if (m_t >= TX_LEN + BLIND && rx_valid) begin
        if (rx_chk_ok) begin
          m_reply = rx_data; m_status = 2'b00; m_done = 1;
        end else attempt_failed(2'b10);
      end else if (m_t == TX_LEN + TMO - 1) attempt_failed(2'b01);
      else m_t++;
    end
  end

  // Per-cycle comparison against the model, after the DUT's registers have settled.
  always @(posedge clk) begin
    logic in_att, e_wr, e_rd, e_dout, e_rxen;
    #1;
    if (done) done_cnt++;
    in_att = m_busy && !m_done && !m_gap;
    e_wr   = in_att && (m_t < TX_LEN);
    e_dout = e_wr ? m_frame[FW - 1 - m_t / BP] : 1'b0;
    e_rd   = in_att && (m_t >= TX_LEN);
    e_rxen = e_rd && (m_t >= TX_LEN + BLIND);
    chk("cyc_busy", 32'(busy), 32'(m_busy));
    chk("cyc_done", 32'(done), 32'(m_done));
    chk("cyc_write", 32'(wr), 32'(e_wr));
    chk("cyc_dout", 32'(dout), 32'(e_dout));
    chk("cyc_read", 32'(rd), 32'(e_rd));
    chk("cyc_rx_en", 32'(rx_en), 32'(e_rxen));
    chk("cyc_reply", 32'(reply), 32'(m_reply));
    chk("cyc_retry", 32'(retry_cnt), 32'(m_retry));
    if (!m_busy || m_done) chk("cyc_status", 32'(status), 32'(m_status));
  end

  // ---------------- directed scenarios ----------------
  task automatic launch(input logic [1:0] md, input logic [1:0] ty, input logic [15:0] d);
    mode = md; typ = ty; tx_data = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_rx_en(input logic lvl, input int lim, input string nm);
    int n = 0;
    while (rx_en !== lvl && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (n >= lim) chk(nm, 32'(rx_en), 32'(lvl));
  endtask

  task automatic wait_done(input int lim, input string nm);
    int n = 0;
    while (done !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (n >= lim) chk(nm, 32'(done), 32'd1);
  endtask

  initial begin
    logic [30:0] lit;
    logic [30:0] cap;
    int wcnt, held_err, k, d0;
    lit = 31'b101010_11_01_1010010111000011_0_0101;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_status", 32'(status), 32'd0);
    chk("reset_reply", 32'(reply), 32'd0);

    // Serialisation of A5C3 plus a blind-time rx_valid and a good reply.
    launch(2'b11, 2'b01, 16'hA5C3);
    cap = '0; wcnt = 0; held_err = 0; k = 0;
    while (wr === 1'b1 && k < 200) begin
      if (k % BP == 0) cap = {cap[29:0], dout};
      else if (dout !== cap[0]) held_err++;
      wcnt++; k++;
      @(negedge clk);
    end
    chk("ser_frame", 32'(cap), 32'(lit));
    chk("ser_write_len", 32'(wcnt), 32'd124);
    chk("ser_bit_hold", 32'(held_err), 32'd0);
    chk("ser_read_after", 32'(rd), 32'd1);
    repeat (2) @(negedge clk);
    rx_valid = 1'b1; rx_chk_ok = 1'b1; rx_data = 8'hFF;
    chk("blind_rx_en", 32'(rx_en), 32'd0);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("listen5_rx_en", 32'(rx_en), 32'd1);
    rx_valid = 1'b1; rx_chk_ok = 1'b1; rx_data = 8'h5A;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("good_done", 32'(done), 32'd1);
    chk("good_status", 32'(status), 32'd0);
    chk("good_reply", 32'(reply), 32'h5A);
    chk("good_retry", 32'(retry_cnt), 32'd0);
    @(negedge clk);
    chk("good_idle", 32'(busy), 32'd0);

    // Silent receiver, with a start-while-busy and a tx_data change mid-flight.
    launch(2'b00, 2'b10, 16'h1234);
    wcnt = 0; k = 0;
    while (done !== 1'b1 && k < 600) begin
      if (wr === 1'b1) wcnt++;
      if (k == 20) begin start = 1'b1; tx_data = 16'hFFFF; mode = 2'b11; end
      if (k == 21) start = 1'b0;
      k++;
      @(negedge clk);
    end
    chk("silent_done_at", 32'(k), 32'd329);
    chk("silent_write_cycles", 32'(wcnt), 32'd248);
    chk("silent_status", 32'(status), 32'd1);
    chk("silent_retry", 32'(retry_cnt), 32'd1);
    chk("silent_reply", 32'(reply), 32'h5A);
    @(negedge clk);

    // Two bad-checksum replies.
    launch(2'b01, 2'b00, 16'h0F0F);
    wait_rx_en(1'b1, 300, "bad1_wait");
    rx_valid = 1'b1; rx_chk_ok = 1'b0; rx_data = 8'h77;
    @(negedge clk);
    rx_valid = 1'b0;
    wait_rx_en(1'b1, 400, "bad2_wait");
    rx_valid = 1'b1; rx_chk_ok = 1'b0; rx_data = 8'h66;
    @(negedge clk);
    rx_valid = 1'b0;
    wait_done(10, "bad_done_wait");
    chk("bad_done", 32'(done), 32'd1);
    chk("bad_status", 32'(status), 32'd2);
    chk("bad_retry", 32'(retry_cnt), 32'd1);
    chk("bad_reply", 32'(reply), 32'h5A);
    repeat (2) @(negedge clk);

    // Abort with enable low at TX bit 10; a start during enable low is ignored.
    d0 = done_cnt;
    launch(2'b10, 2'b11, 16'hBEEF);
    repeat (40) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("en_abort_dout", 32'(dout), 32'd0);
    chk("en_abort_write", 32'(wr), 32'd0);
    chk("en_abort_busy", 32'(busy), 32'd0);
    chk("en_abort_status_kept", 32'(status), 32'd2);
    chk("en_abort_reply_kept", 32'(reply), 32'h5A);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("en_low_start_ignored", 32'(busy), 32'd0);
    chk("en_abort_no_done", 32'(done_cnt - d0), 32'd0);

    // Abort with reset at TX bit 10.
    launch(2'b10, 2'b11, 16'hBEEF);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_abort_write", 32'(wr), 32'd0);
    chk("rst_abort_busy", 32'(busy), 32'd0);
    chk("rst_abort_status", 32'(status), 32'd0);
    chk("rst_abort_reply", 32'(reply), 32'd0);
    chk("rst_abort_no_done", 32'(done_cnt - d0), 32'd0);
    @(negedge clk);

    // Timeout on the first attempt, good reply on the retry.
    launch(2'b01, 2'b01, 16'h8001);
    wait_rx_en(1'b1, 300, "rec_wait1");
    wait_rx_en(1'b0, 100, "rec_wait_low");
    wait_rx_en(1'b1, 300, "rec_wait2");
    rx_valid = 1'b1; rx_chk_ok = 1'b1; rx_data = 8'hC3;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("rec_done", 32'(done), 32'd1);
    chk("rec_status", 32'(status), 32'd0);
    chk("rec_retry", 32'(retry_cnt), 32'd1);
    chk("rec_reply", 32'(reply), 32'hC3);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
